// File: rtl/mul_mantissa_seq_pkg.sv
// Shared definitions for the sequential mantissa multiplier: mantissa widths,
// FSM state encoding and a small sizing helper.
package mul_mantissa_seq_pkg;

   localparam int MANT_W_SP = 24;
   localparam int MANT_W_DP = 53;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   // Number of CHUNK_W-wide slices needed to cover a width-bit operand.
   function automatic int ceil_div(input int width, input int chunk);
      return (width + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/mul_mantissa_seq_adder.sv
// Parametrised unsigned adder used for the accumulate step.
module mul_mantissa_seq_adder #(
   parameter int W = 48
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Sum,
   output logic         Carry
);

   // Full-width add with the carry split off the top.
   always_comb begin
      {Carry, Sum} = {1'b0, A} + {1'b0, B};
   end

endmodule

// File: rtl/mul_mantissa_seq.sv
// Multi-cycle mantissa multiplier: retires one CHUNK_W-bit slice of MantB per
// cycle into a 2*MANT_W accumulator, then presents the product on a
// valid/ready output that holds under backpressure.
module mul_mantissa_seq
   import mul_mantissa_seq_pkg::*;
#(
   parameter int MANT_W  = MANT_W_SP,
   parameter int CHUNK_W = 8
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                InValid,
   output logic                InReady,
   input  logic [MANT_W-1:0]   MantA,
   input  logic [MANT_W-1:0]   MantB,
   output logic                OutValid,
   input  logic                OutReady,
   output logic [2*MANT_W-1:0] MULResult,
   output logic                Busy
);

   localparam int NCHUNK = ceil_div(MANT_W, CHUNK_W);
   localparam int PAD_W  = NCHUNK * CHUNK_W;
   localparam int ACC_W  = 2 * MANT_W;
   localparam int PP_W   = MANT_W + CHUNK_W;
   localparam int EXT_W  = (PP_W > ACC_W) ? PP_W : ACC_W;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

   mul_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [MANT_W-1:0] a_q, a_d;
   logic [PAD_W-1:0]  b_q, b_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  result_q, result_d;

   logic [CHUNK_W-1:0] slice_s;
   logic [PP_W-1:0]    pp_s;
   logic [ACC_W-1:0]   shifted_s;
   logic [ACC_W-1:0]   sum_s;

   // Select the MantB slice addressed by the chunk counter (slice 0 = LSBs).
   always_comb begin
      slice_s = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            slice_s = b_q[k*CHUNK_W +: CHUNK_W];
         end else begin
            slice_s = slice_s;
         end
      end
   end

   // Behavioural MANT_W x CHUNK_W partial product.
   always_comb begin
      pp_s = {{CHUNK_W{1'b0}}, a_q} * {{MANT_W{1'b0}}, slice_s};
   end

   // Align the partial product to its slice position with a mux on the counter.
   always_comb begin
      shifted_s = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            shifted_s = ACC_W'(EXT_W'(pp_s) << (CHUNK_W * k));
         end else begin
            shifted_s = shifted_s;
         end
      end
   end

   // The running sum is bounded by (2^MANT_W-1)^2, so the carry-out is never set.
   mul_mantissa_seq_adder #(
      .W (ACC_W)
   ) u_adder (
      .A     (acc_q),
      .B     (shifted_s),
      .Sum   (sum_s),
      .Carry ()
   );

   // Handshake decodes; InReady allows a new op on the same edge a result retires.
   always_comb begin
      InReady   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OutReady);
      OutValid  = (state_q == ST_DONE);
      Busy      = (state_q == ST_CALC);
      MULResult = result_q;
   end

   // Next-state logic: operand load, per-slice accumulate, result capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (InValid) begin
               a_d     = MantA;
               b_d     = PAD_W'(MantB);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            acc_d = sum_s;
            if (cnt_q == CNT_LAST) begin
               result_d = sum_s;
               cnt_d    = '0;
               state_d  = ST_DONE;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (OutReady) begin
               if (InValid) begin
                  a_d     = MantA;
                  b_d     = PAD_W'(MantB);
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_CALC;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers; Reset drops any in-flight operation.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

endmodule
